eth_tx_frame_arb: RTL and testbench

Frame-level round-robin arbiter that shares one GMII transmit MAC between several AXI-Stream frame sources. Sits directly upstream of the 8-bit AXI-to-GMII transmitter, whose tready pattern (stalls during preamble/IFG) it absorbs through a registered output stage. A grant is held for a whole frame, from first word to tlast, so frames never interleave on the MAC.

---
 rtl/eth_tx_arb_pkg.sv | 21 ++
 rtl/eth_arb_rr_select.sv | 37 +++
 rtl/eth_tx_frame_arb.sv | 185 ++++++++++++++++++
 tb/tb_eth_tx_frame_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
//==============================================================================
// Module      : eth_tx_arb_pkg
// Description : Shared state encoding and tuser field constants for the
//               Ethernet TX frame arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package eth_tx_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // tuser bit carrying the frame-error flag; remaining bits are opaque
    localparam int c_tuser_err_bit = 0;

endpackage

`default_nettype wire

// File: rtl/eth_arb_rr_select.sv
//==============================================================================
// Module      : eth_arb_rr_select
// Description : Combinational round-robin picker; returns the first requester
//               found scanning upward from last_i+1, wrapping modulo N.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module eth_arb_rr_select #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] w_cand;

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        w_cand  = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = W'((int'(last_i) + k) % N);
            if (req_i[w_cand]) begin
                found_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_tx_frame_arb.sv
//==============================================================================
// Module      : eth_tx_frame_arb
// Description : Frame-level round-robin arbiter feeding one GMII TX MAC from
//               S_COUNT AXI-Stream sources, with a registered skid output.
//               Optional macro ETH_TX_ARB_PAUSE_EN adds the tx_pause input.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module eth_tx_frame_arb #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int S_ID_WIDTH = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef ETH_TX_ARB_PAUSE_EN
    input  logic                          tx_pause,
`endif
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [S_ID_WIDTH-1:0]         m_axis_tid,
    output logic                          grant_valid,
    output logic [S_ID_WIDTH-1:0]         grant_index
);

    import eth_tx_arb_pkg::*;

    localparam int WORD_W = S_ID_WIDTH + USER_WIDTH + 1 + DATA_WIDTH;

    arb_state_e              state_q, state_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [S_ID_WIDTH-1:0]   grant_index_q, grant_index_d;
    logic [S_ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                    tready_int_q;
    logic                    m_valid_q, m_valid_d;
    logic                    temp_valid_q, temp_valid_d;
    logic [WORD_W-1:0]       m_word_q, m_word_d;
    logic [WORD_W-1:0]       temp_word_q, temp_word_d;

    logic                    w_found;
    logic [S_ID_WIDTH-1:0]   w_pick;
    logic                    w_pause;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [USER_WIDTH-1:0]   w_sel_user;
    logic                    w_in_valid;
    logic                    w_in_accept;
    logic                    w_tready_int_d;
    logic [WORD_W-1:0]       w_in_word;

`ifdef ETH_TX_ARB_PAUSE_EN
    assign w_pause = tx_pause;
`else
    assign w_pause = 1'b0;
`endif

    eth_arb_rr_select #(
        .N (S_COUNT),
        .W (S_ID_WIDTH)
    ) u_rr_select (
        .req_i   (s_axis_tvalid),
        .last_i  (last_grant_q),
        .found_o (w_found),
        .idx_o   (w_pick)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_user  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_index_q == S_ID_WIDTH'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_ready
            assign s_axis_tready[gi] = grant_valid_q && tready_int_q &&
                                       (grant_index_q == S_ID_WIDTH'(gi));
        end
    endgenerate

    assign w_in_valid     = grant_valid_q && w_sel_valid;
    assign w_in_accept    = w_in_valid && tready_int_q;
    assign w_in_word      = {grant_index_q, w_sel_user, w_sel_last, w_sel_data};
    assign w_tready_int_d = m_axis_tready ||
                            (!temp_valid_q && (!m_valid_q || !w_in_accept));

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        last_grant_d  = last_grant_q;
        case (state_q)
            IDLE: begin
                if (w_found && !w_pause) begin
                    grant_index_d = w_pick;
                    grant_valid_d = 1'b1;
                    state_d       = XFER;
                end
            end
            XFER: begin
                if (w_in_accept && w_sel_last) begin
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_index_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid stage: a word accepted while the output is stalled parks in temp.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_word_d     = m_word_q;
        temp_valid_d = temp_valid_q;
        temp_word_d  = temp_word_q;
        if (tready_int_q) begin
            if (m_axis_tready || !m_valid_q) begin
                m_valid_d = w_in_valid;
                m_word_d  = w_in_word;
            end else begin
                temp_valid_d = w_in_valid;
                temp_word_d  = w_in_word;
            end
        end else if (m_axis_tready) begin
            m_valid_d    = temp_valid_q;
            m_word_d     = temp_word_q;
            temp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            last_grant_q  <= S_ID_WIDTH'(S_COUNT - 1);
            tready_int_q  <= 1'b0;
            m_valid_q     <= 1'b0;
            m_word_q      <= '0;
            temp_valid_q  <= 1'b0;
            temp_word_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            last_grant_q  <= last_grant_d;
            tready_int_q  <= w_tready_int_d;
            m_valid_q     <= m_valid_d;
            m_word_q      <= m_word_d;
            temp_valid_q  <= temp_valid_d;
            temp_word_q   <= temp_word_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_word_q[DATA_WIDTH-1:0];
    assign m_axis_tlast  = m_word_q[DATA_WIDTH];
    assign m_axis_tuser  = m_word_q[DATA_WIDTH+1 +: USER_WIDTH];
    assign m_axis_tid    = m_word_q[WORD_W-1 -: S_ID_WIDTH];
    assign grant_valid   = grant_valid_q;
    assign grant_index   = grant_index_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_frame_arb.sv
//==============================================================================
// Module      : tb_eth_tx_frame_arb
// Description : Directed self-checking bench for eth_tx_frame_arb (4 ports,
//               8-bit data, 17-bit tuser); pause steps need ETH_TX_ARB_PAUSE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_eth_tx_frame_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata  = '0;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast  = '0;
    logic [67:0] s_tuser  = '0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [16:0] m_tuser;
    logic [1:0]  m_tid;
    logic        grant_valid;
    logic [1:0]  grant_index;
`ifdef ETH_TX_ARB_PAUSE_EN
    logic        tx_pause = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // source word {tuser, tlast, tdata}; expected word {tid, tuser, tlast, tdata}
    logic [25:0] src_q [4][$];
    logic [27:0] exp_q [$];
    int          ts_q  [$];
    logic [3:0]  hs    = '0;
    logic [3:0]  hold  = '0;

    eth_tx_frame_arb #(
        .S_COUNT    (4),
        .DATA_WIDTH (8),
        .USER_WIDTH (17),
        .S_ID_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ETH_TX_ARB_PAUSE_EN
        .tx_pause      (tx_pause),
`endif
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tid    (m_tid),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) hs = s_tvalid & s_tready;

    // Source models: pop on the handshake seen last negedge, then present the next word.
    always @(posedge clk) begin
        logic [25:0] w;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && !hold[i]) begin
                w = src_q[i][0];
                s_tvalid[i] = 1'b1;
            end else begin
                w = '0;
                s_tvalid[i] = 1'b0;
            end
            s_tdata[i*8 +: 8]   = w[7:0];
            s_tlast[i]          = w[8];
            s_tuser[i*17 +: 17] = w[25:9];
        end
    end

    // Output scoreboard.
    always @(negedge clk) begin
        logic [27:0] got, want;
        if (!rst && m_tvalid && m_tready) begin
            got = {m_tid, m_tuser, m_tlast, m_tdata};
            ts_q.push_back(cyc);
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL out_extra: observed word %h, expected no word", got);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                n_assert++;
                assert (got === want) else begin
                    n_fail++;
                    $error("FAIL out_word: observed %h expected %h", got, want);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int p, input int n, input logic [7:0] base,
                             input logic [16:0] u_mid, input logic [16:0] u_last);
        for (int k = 0; k < n; k++)
            src_q[p].push_back({(k == n-1) ? u_last : u_mid, 1'(k == n-1), 8'(base + k)});
    endtask

    task automatic expect_frame(input int p, input int n, input logic [7:0] base,
                                input logic [16:0] u_mid, input logic [16:0] u_last);
        for (int k = 0; k < n; k++)
            exp_q.push_back({2'(p), (k == n-1) ? u_last : u_mid, 1'(k == n-1), 8'(base + k)});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        hold = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ts_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_m_tvalid",     m_tvalid,    0);
        check("rst_s_tready",     s_tready,    0);
        check("rst_grant_valid",  grant_valid, 0);
        check("rst_grant_index",  grant_index, 0);
        check("rst_m_tid",        m_tid,       0);
        check("rst_m_tdata",      m_tdata,     0);
        check("rst_m_tlast",      m_tlast,     0);
        check("rst_m_tuser",      m_tuser,     0);
        rst = 1'b0;
        @(negedge clk);

        // 64-byte frame on port 0, latency and content
        add_frame(0, 64, 8'h01, 17'h0, 17'h0);
        expect_frame(0, 64, 8'h01, 17'h0, 17'h0);
        @(negedge clk);
        check("t1_c0_grant_valid", grant_valid, 0);
        @(negedge clk);
        check("t1_c1_grant_valid", grant_valid, 1);
        check("t1_c1_grant_index", grant_index, 0);
        check("t1_c1_s_tready",    s_tready,    4'b0001);
        check("t1_c1_m_tvalid",    m_tvalid,    0);
        @(negedge clk);
        check("t1_c2_m_tvalid",    m_tvalid,    1);
        check("t1_c2_m_tid",       m_tid,       0);
        check("t1_c2_m_tdata",     m_tdata,     8'h01);
        drain("t1");
        check("t1_len", ts_q.size(), 64);

        // Round robin 0,1,2,0 with one gap cycle between frames
        do_reset();
        add_frame(0, 3, 8'h00, 17'h0, 17'h0);
        add_frame(0, 3, 8'h30, 17'h0, 17'h0);
        add_frame(1, 3, 8'h10, 17'h0, 17'h0);
        add_frame(2, 3, 8'h20, 17'h0, 17'h0);
        expect_frame(0, 3, 8'h00, 17'h0, 17'h0);
        expect_frame(1, 3, 8'h10, 17'h0, 17'h0);
        expect_frame(2, 3, 8'h20, 17'h0, 17'h0);
        expect_frame(0, 3, 8'h30, 17'h0, 17'h0);
        drain("t2");
        check("t2_len", ts_q.size(), 12);
        if (ts_q.size() == 12)
            for (int k = 1; k < 12; k++)
                check($sformatf("t2_gap_%0d", k), ts_q[k] - ts_q[k-1], (k % 3 == 0) ? 2 : 1);

        // MAC-like back-pressure: 8 cycles ready, 8 cycles stalled
        @(negedge clk);
        add_frame(1, 20, 8'h40, 17'h0, 17'h0);
        expect_frame(1, 20, 8'h40, 17'h0, 17'h0);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            m_tready = ((c / 8) % 2 == 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        drain("t3");

        // Granted port pauses mid-frame while port 3 waits
        @(negedge clk);
        add_frame(2, 6, 8'h60, 17'h0, 17'h0);
        add_frame(3, 2, 8'h70, 17'h0, 17'h0);
        expect_frame(2, 6, 8'h60, 17'h0, 17'h0);
        expect_frame(3, 2, 8'h70, 17'h0, 17'h0);
        repeat (3) @(negedge clk);
        hold[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4_hold_gi_%0d", c), grant_index, 2);
            check($sformatf("t4_hold_gv_%0d", c), grant_valid, 1);
        end
        hold[2] = 1'b0;
        drain("t4");

        // Error flag plus tag in tuser passes through untouched
        @(negedge clk);
        add_frame(3, 3, 8'h80, {16'hABCD, 1'b0}, {16'hABCD, 1'b1});
        expect_frame(3, 3, 8'h80, 17'h1579A, 17'h1579B);
        drain("t5");

`ifdef ETH_TX_ARB_PAUSE_EN
        // Pause mid-frame: frame completes, next grant waits for release
        @(negedge clk);
        add_frame(0, 4, 8'h90, 17'h0, 17'h0);
        expect_frame(0, 4, 8'h90, 17'h0, 17'h0);
        expect_frame(1, 2, 8'hA0, 17'h0, 17'h0);
        repeat (2) @(negedge clk);
        tx_pause = 1'b1;
        add_frame(1, 2, 8'hA0, 17'h0, 17'h0);
        repeat (12) @(negedge clk);
        check("t6_paused_gv",   grant_valid,  0);
        check("t6_paused_left", exp_q.size(), 2);
        tx_pause = 1'b0;
        drain("t6");
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
